// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes and optional two's-complement input.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Smallest digit count whose decimal range covers 2^bits - 1.
    function automatic int digits_needed(input int bits);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << bits) - 64'd1;
        pow10   = 64'd10;
        d       = 1;
        while (pow10 <= max_val) begin
            d     = d + 1;
            pow10 = pow10 * 64'd10;
        end
        return d;
    endfunction

    if (BIN_W < 2) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W - 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [SR_W-1:0]    shift_reg;
    logic [SR_W-1:0]    adjusted;
    logic [SR_W-1:0]    shifted;
    logic [CNT_W-1:0]   count;
    logic               sign_reg;
    logic               neg_in;
    logic [BIN_W-1:0]   magnitude;

    // The negation wraps in BIN_W bits, so the most negative value maps onto
    // its own bit pattern, which read unsigned is exactly its magnitude.
    always_comb begin
        neg_in    = (SIGNED != 0) && bin_in[BIN_W-1];
        magnitude = neg_in ? (~bin_in + BIN_W'(1)) : bin_in;
    end

    always_comb begin
        adjusted = shift_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_reg[BIN_W + 4*d +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*d +: 4] = shift_reg[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        shifted = adjusted << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == CNT_W'(1)) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Results are published on the final shift edge and then held untouched
    // until the next conversion finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            count     <= '0;
            sign_reg  <= 1'b0;
            bcd_out   <= '0;
            sign_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= {{BCD_W{1'b0}}, magnitude};
                        count     <= CNT_W'(BIN_W);
                        sign_reg  <= neg_in;
                    end
                end
                SHIFT: begin
                    shift_reg <= shifted;
                    count     <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        bcd_out  <= shifted[SR_W-1:BIN_W];
                        sign_out <= sign_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, processing one input bit per clock.
- Generalises the team's 8-bit combinational converter:
  - parametrised input width and digit count;
  - optional two's-complement input with a sign output;
  - valid/ready handshakes on input and output.
- Sits between binary datapaths (counters, ADC results) and display/UART formatting logic.
- Trades latency for area: one digit-adjust bank, reused for BIN_W cycles.

Parameters:
- BIN_W, 8, input binary width in bits; must be 2 or more.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration fails otherwise.
- SIGNED, 0, 0 = unsigned input; 1 = two's-complement input, output is magnitude plus sign_out.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  bin_in holds a value to convert
- in_ready  out  1  converter can accept a value
- bin_in  in  BIN_W  binary operand
- out_valid  out  1  bcd_out/sign_out hold a finished result
- out_ready  in  1  downstream accepts the result
- bcd_out  out  4*DIGITS  packed BCD; [3:0] = ones, [7:4] = tens, ..., most significant digit at the top
- sign_out  out  1  1 = input was negative (always 0 when SIGNED=0)
- busy  out  1  conversion in progress (state SHIFT)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, busy=0, bcd_out=0, sign_out=0, internal shift register and bit counter cleared.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1, load the magnitude into the low BIN_W bits of an internal (4*DIGITS+BIN_W)-bit shift register, with the BCD field zeroed.
  - Magnitude is bin_in when SIGNED=0, or when SIGNED=1 and bin_in MSB=0. Otherwise it is the two's-complement negation, computed in BIN_W bits as unsigned; -2^(BIN_W-1) yields 2^(BIN_W-1) correctly.
  - On the same edge: latch the sign, set counter=BIN_W, go to SHIFT.
- SHIFT (in_ready=0, busy=1), each cycle:
  - for every BCD digit of the shift register whose value is 5 or more, add 3, all digits in parallel;
  - then shift the whole register left by 1 and decrement the counter.
  - After the BIN_W-th shift, go to DONE.
  - bcd_out and sign_out are loaded from the register and sign latch on that same edge.
- DONE:
  - out_valid=1; bcd_out and sign_out are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid falls and in_ready rises on that edge.
  - bcd_out keeps its last value after the handshake; it is not cleared.
- Latency:
  - accept at edge k; out_valid is high after edge k+BIN_W;
  - with out_ready tied high, in_ready returns after edge k+BIN_W+1;
  - throughput is one conversion per BIN_W+2 cycles.
- Accepted input is registered at accept; bin_in and in_valid are ignored while not in IDLE, so no input is lost or overwritten mid-conversion.
- Zero input: result 0, sign_out=0. In signed mode, negative zero cannot occur.
- out_ready asserted before out_valid has no effect.
- Backpressure: result held indefinitely while out_ready=0.
- Reset mid-conversion or during DONE aborts immediately to the reset values; the result is discarded.
- All arithmetic is unsigned on 4-bit digit fields; the add-3 never carries out of its digit because the operand is 9 or less.

Test Plan:
- BIN_W=8, DIGITS=3, SIGNED=0: bin_in=255, out_ready=1 -> out_valid exactly 8 cycles after accept; bcd_out=0x255, sign_out=0; in_ready high one cycle later.
- Exhaustive unsigned sweep 0..255 with random out_ready stalls -> every result matches the decimal reference model; 0 -> 0x000, 99 -> 0x099, 100 -> 0x100; no result dropped or duplicated.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> bcd_out stable and in_ready=0 throughout; bin_in toggled during SHIFT/DONE does not alter the result.
- SIGNED=1, BIN_W=8: -128 -> 0x128/sign 1; -1 -> 0x001/sign 1; 127 -> 0x127/sign 0; 0 -> 0x000/sign 0.
- BIN_W=16, DIGITS=5: 65535 -> 0x65535 after 16 cycles; 10000 -> 0x10000.
- Assert rst at the 4th SHIFT cycle -> out_valid=0, busy=0, in_ready=1, bcd_out=0 immediately. The next conversion of 42 returns 0x042 correctly.
